bus_arbiter_ctrl: RTL and testbench
===================================

# bus_arbiter_ctrl

Two-master bus arbiter and address decoder for the shared 32-bit memory bus. It grants the bus to one master at a time, drives the granted master's address and write strobe onto the bus, and decodes the address into slave chip-selects. It also produces the registered 2-bit read-data select consumed by the downstream 3-input 32-bit read-data mux: 00 selects the default/idle word, 10 selects slave 0, 01 selects slave 1.

## Interface
- ADDR_W, 8, bus address width
- S0_BASE, 8'h00, slave 0 base address
- S1_BASE, 8'h20, slave 1 base address
- SPAN_W, 5, log2 of each slave's window size (32 words)

- clk  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- m0_req  in  1  master 0 bus request / access valid
- m0_wr  in  1  master 0 write (1) / read (0)
- m0_addr  in  ADDR_W  master 0 address
- m1_req  in  1  master 1 bus request / access valid
- m1_wr  in  1  master 1 write / read
- m1_addr  in  ADDR_W  master 1 address
- m0_grant  out  1  master 0 owns the bus (registered)
- m1_grant  out  1  master 1 owns the bus (registered)
- bus_addr  out  ADDR_W  granted master's address (combinational)
- bus_wr  out  1  granted master's write strobe, gated by its req
- s0_sel  out  1  slave 0 chip select (combinational)
- s1_sel  out  1  slave 1 chip select (combinational)
- rd_sel  out  2  read-data mux select, registered: 00 none, 10 slave 0, 01 slave 1

## Operation
- Two-state FSM: M0_GRANT, M1_GRANT. Master 0 is the default owner.
- M0_GRANT -> M1_GRANT when m0_req=0 and m1_req=1. Otherwise stay.
- M1_GRANT -> M0_GRANT when m1_req=0, regardless of m0_req. Otherwise stay. A master that holds req keeps the bus, so there is no preemption.
- m0_grant = (state==M0_GRANT), m1_grant = (state==M1_GRANT). These are decoded from the state register and are exactly one-hot at all times.
- bus_addr = granted master's addr. bus_wr = granted master's wr AND its req.
- Valid access: the granted master's req=1.
- s0_sel = 1 when a valid access is in progress and bus_addr[ADDR_W-1:SPAN_W] == S0_BASE[ADDR_W-1:SPAN_W]. s1_sel uses S1_BASE in the same way.
- An address in neither window asserts no select. The access completes silently and rd_sel reads 00.
- A non-granted master's req, wr, and addr have no effect on any output.
- rd_sel register, updated every clock:
  - 10 if the current cycle is a valid read (bus_wr=0) with s0_sel=1
  - 01 if it is a valid read with s1_sel=1
  - 00 otherwise, including writes and idle cycles
- Codes 11 are never produced.

## Timing
- Reset (reset_n=0 at a rising edge): state=M0_GRANT, m0_grant=1, m1_grant=0, rd_sel=00. The combinational outputs follow from m0's inputs.
- Reset mid-transfer: the next edge forces M0_GRANT and rd_sel=00, even if M1 was granted with req held.
- Grant handover latency: 1 clock from the edge that samples the transfer condition. No dead cycle, and no cycle with both grants or neither grant.
- Address, write strobe, and chip selects are valid in the same cycle as the granted master's req.
- rd_sel lags the read address by exactly 1 clock, matching the synchronous memory read latency. Back-to-back reads to s0 then s1 give rd_sel 10, then 01, on consecutive cycles.
- Both reqs rising in the same cycle while in M0_GRANT: M0 keeps the bus.
- Both reqs high in M1_GRANT: M1 keeps the bus until it drops req.

## Structure
- Shared package/header: state encodings (M0_GRANT=1'b0, M1_GRANT=1'b1), the rd_sel codes (RD_NONE=2'b00, RD_S0=2'b10, RD_S1=2'b01), and the default base addresses.
- One natural sub-module, bus_addr_decoder: purely combinational; takes bus_addr and valid, outputs s0_sel and s1_sel. The arbiter FSM, address/strobe mux, and rd_sel register stay in the top module.

## Test plan
- Reset, no reqs -> m0_grant=1, m1_grant=0, rd_sel=00. Release reset with m1_req=1 and m0_req=0 -> m1_grant=1 after one edge.
- M0 granted, m0_req=1, read of m0_addr=8'h05 -> s0_sel=1 the same cycle, rd_sel=10 the next cycle. Then a read of 8'h25 -> s1_sel=1, rd_sel=01 the next cycle.
- M1 granted and holding req, m0_req=1 for 5 cycles -> m1_grant stays 1. Drop m1_req -> m0_grant=1 after one edge, never both grants high.
- Write of 8'h10 with m0_wr=1 -> s0_sel=1, bus_wr=1, rd_sel stays 00. Read of 8'h40 (unmapped) -> no select asserted, rd_sel=00.
- M1 granted, reading 8'h21, reset_n=0 for one edge -> m0_grant=1 and rd_sel=00 after that edge.
- Non-granted master toggles addr/wr randomly -> bus_addr, bus_wr, and the selects track only the granted master.

Source files
------------

// File: rtl/bus_arbiter_ctrl_pkg.sv
// Shared definitions for the two-master bus arbiter and its address decoder.
// Contents:
//   - arb_state_t : arbiter FSM encoding (M0_GRANT = 1'b0, M1_GRANT = 1'b1)
//   - RD_*        : read-data mux select codes (00 idle word, 10 slave 0, 01 slave 1)
//   - DEF_*       : default bus geometry and slave window bases
//   - rd_code()   : maps a cycle's access type and chip selects to an rd_sel code
package bus_arbiter_ctrl_pkg;

  typedef enum logic {
    M0_GRANT = 1'b0,
    M1_GRANT = 1'b1
  } arb_state_t;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_S0   = 2'b10;
  localparam logic [1:0] RD_S1   = 2'b01;

  localparam int         DEF_ADDR_W  = 8;
  localparam int         DEF_SPAN_W  = 5;
  localparam logic [7:0] DEF_S0_BASE = 8'h00;
  localparam logic [7:0] DEF_S1_BASE = 8'h20;

  // Slave 0 wins if both selects are ever set (overlapping windows), so the
  // code 2'b11 can never be produced.
  function automatic logic [1:0] rd_code(input logic valid_rd,
                                         input logic s0,
                                         input logic s1);
    logic [1:0] code;
    if (valid_rd && s0) begin
      code = RD_S0;
    end else if (valid_rd && s1) begin
      code = RD_S1;
    end else begin
      code = RD_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/bus_arbiter_ctrl_bus_addr_decoder.sv
// Purely combinational slave chip-select decoder.
// Ports:
//   bus_addr [ADDR_W] in  : address currently driven on the bus
//   valid             in  : granted master is presenting an access
//   s0_sel            out : address falls in slave 0's window
//   s1_sel            out : address falls in slave 1's window
// A window is the 2**SPAN_W words starting at the base; only the bits above
// SPAN_W take part in the match.
module bus_addr_decoder
  import bus_arbiter_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] S0_BASE = DEF_S0_BASE,
  parameter logic [ADDR_W-1:0] S1_BASE = DEF_S1_BASE,
  parameter int                SPAN_W  = DEF_SPAN_W
) (
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              valid,
  output logic              s0_sel,
  output logic              s1_sel
);

  // Shifting out the in-window offset compares only the page bits.
  logic [ADDR_W-1:0] page_s;
  logic [ADDR_W-1:0] s0_page_s;
  logic [ADDR_W-1:0] s1_page_s;

  assign page_s    = bus_addr >> SPAN_W;
  assign s0_page_s = S0_BASE >> SPAN_W;
  assign s1_page_s = S1_BASE >> SPAN_W;

  // Chip-select decode, gated by a valid access
  always_comb begin
    s0_sel = 1'b0;
    s1_sel = 1'b0;
    if (valid) begin
      s0_sel = (page_s == s0_page_s);
      s1_sel = (page_s == s1_page_s);
    end else begin
      s0_sel = 1'b0;
      s1_sel = 1'b0;
    end
  end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Two-master bus arbiter and address decoder for the shared memory bus.
// Ports:
//   clk, reset_n             : rising-edge clock, synchronous active-low reset
//   m0_req/m0_wr/m0_addr     : master 0 request, write flag, address
//   m1_req/m1_wr/m1_addr     : master 1 request, write flag, address
//   m0_grant, m1_grant       : one-hot bus ownership, decoded from the state register
//   bus_addr, bus_wr         : granted master's address and req-gated write strobe
//   s0_sel, s1_sel           : slave chip selects (combinational)
//   rd_sel                   : registered read-data mux select (00 none, 10 s0, 01 s1)
// Master 0 is the default owner; an owner keeps the bus while it holds req.
module bus_arbiter_ctrl
  import bus_arbiter_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] S0_BASE = DEF_S0_BASE,
  parameter logic [ADDR_W-1:0] S1_BASE = DEF_S1_BASE,
  parameter int                SPAN_W  = DEF_SPAN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic [1:0]        rd_sel
);

  arb_state_t        state_r;
  arb_state_t        state_next_s;
  logic [ADDR_W-1:0] bus_addr_s;
  logic              bus_wr_s;
  logic              valid_s;
  logic              s0_sel_s;
  logic              s1_sel_s;
  logic [1:0]        rd_sel_r;
  logic [1:0]        rd_sel_next_s;

  // Arbitration: hand over only when the owner has released its request
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      M0_GRANT: begin
        if (!m0_req && m1_req) begin
          state_next_s = M1_GRANT;
        end else begin
          state_next_s = M0_GRANT;
        end
      end
      M1_GRANT: begin
        if (!m1_req) begin
          state_next_s = M0_GRANT;
        end else begin
          state_next_s = M1_GRANT;
        end
      end
      default: state_next_s = M0_GRANT;
    endcase
  end

  // Address / strobe mux: only the granted master reaches the bus
  always_comb begin
    bus_addr_s = m0_addr;
    bus_wr_s   = 1'b0;
    valid_s    = 1'b0;
    case (state_r)
      M0_GRANT: begin
        bus_addr_s = m0_addr;
        bus_wr_s   = m0_wr & m0_req;
        valid_s    = m0_req;
      end
      M1_GRANT: begin
        bus_addr_s = m1_addr;
        bus_wr_s   = m1_wr & m1_req;
        valid_s    = m1_req;
      end
      default: begin
        bus_addr_s = m0_addr;
        bus_wr_s   = 1'b0;
        valid_s    = 1'b0;
      end
    endcase
  end

  bus_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .S0_BASE (S0_BASE),
    .S1_BASE (S1_BASE),
    .SPAN_W  (SPAN_W)
  ) u_dec (
    .bus_addr (bus_addr_s),
    .valid    (valid_s),
    .s0_sel   (s0_sel_s),
    .s1_sel   (s1_sel_s)
  );

  // Read-data select for the next cycle, one clock behind the read address
  always_comb begin
    rd_sel_next_s = rd_code(valid_s & ~bus_wr_s, s0_sel_s, s1_sel_s);
  end

  // State and rd_sel registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= M0_GRANT;
      rd_sel_r <= RD_NONE;
    end else begin
      state_r  <= state_next_s;
      rd_sel_r <= rd_sel_next_s;
    end
  end

  assign m0_grant = (state_r == M0_GRANT);
  assign m1_grant = (state_r == M1_GRANT);
  assign bus_addr = bus_addr_s;
  assign bus_wr   = bus_wr_s;
  assign s0_sel   = s0_sel_s;
  assign s1_sel   = s1_sel_s;
  assign rd_sel   = rd_sel_r;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Scoreboard bench for bus_arbiter_ctrl: each directed vector is driven just
// after a rising edge and its hand-computed expected outputs are queued; a
// monitor pops and compares on the following falling edge.
module tb_bus_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [7:0] m0_addr = 8'h00, m1_addr = 8'h00;
  logic       m0_grant, m1_grant, bus_wr, s0_sel, s1_sel;
  logic [7:0] bus_addr;
  logic [1:0] rd_sel;

  typedef struct packed {
    int         vid;
    logic       eg;    // expected owner: 0 = master 0, 1 = master 1
    logic [7:0] ea;
    logic       ew;
    logic       e0;
    logic       e1;
    logic [1:0] erd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_n   = 0;

  bus_arbiter_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .bus_addr (bus_addr),
    .bus_wr   (bus_wr),
    .s0_sel   (s0_sel),
    .s1_sel   (s1_sel),
    .rd_sel   (rd_sel)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int vid, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, vid, act, exp);
    end
  endtask

  // Monitor: compare mid-cycle, well away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("m0_grant", e.vid, {7'd0, m0_grant}, {7'd0, ~e.eg});
      cmp("m1_grant", e.vid, {7'd0, m1_grant}, {7'd0, e.eg});
      cmp("bus_addr", e.vid, bus_addr, e.ea);
      cmp("bus_wr",   e.vid, {7'd0, bus_wr},   {7'd0, e.ew});
      cmp("s0_sel",   e.vid, {7'd0, s0_sel},   {7'd0, e.e0});
      cmp("s1_sel",   e.vid, {7'd0, s1_sel},   {7'd0, e.e1});
      cmp("rd_sel",   e.vid, {6'd0, rd_sel},   {6'd0, e.erd});
    end
  end

  task automatic step(input logic rst, input logic r0, input logic w0, input logic [7:0] a0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic chk,
                      input logic eg, input logic [7:0] ea, input logic ew,
                      input logic e0, input logic e1, input logic [1:0] erd);
    @(posedge clk);
    #1;
    reset_n = rst;
    m0_req = r0; m0_wr = w0; m0_addr = a0;
    m1_req = r1; m1_wr = w1; m1_addr = a1;
    if (chk) exp_q.push_back('{vid: vec_n, eg: eg, ea: ea, ew: ew, e0: e0, e1: e1, erd: erd});
    vec_n++;
  endtask

  initial begin
    // Reset with no requests
    step(1'b0, 1'b0,1'b0,8'h05, 1'b0,1'b0,8'h21, 1'b0, 1'b0,8'h05,1'b0,1'b0,1'b0,2'b00);
    step(1'b0, 1'b0,1'b0,8'h05, 1'b0,1'b0,8'h21, 1'b1, 1'b0,8'h05,1'b0,1'b0,1'b0,2'b00);
    // Release reset with only m1 requesting -> handover after one edge
    step(1'b1, 1'b0,1'b0,8'h05, 1'b1,1'b0,8'h21, 1'b1, 1'b0,8'h05,1'b0,1'b0,1'b0,2'b00);
    step(1'b1, 1'b0,1'b0,8'h05, 1'b1,1'b0,8'h21, 1'b1, 1'b1,8'h21,1'b0,1'b0,1'b1,2'b00);
    step(1'b1, 1'b1,1'b0,8'h05, 1'b0,1'b0,8'h21, 1'b1, 1'b1,8'h21,1'b0,1'b0,1'b0,2'b01);
    // M0 reads s0 then s1 back to back, then a write, then an unmapped read
    step(1'b1, 1'b1,1'b0,8'h05, 1'b0,1'b0,8'h21, 1'b1, 1'b0,8'h05,1'b0,1'b1,1'b0,2'b00);
    step(1'b1, 1'b1,1'b0,8'h25, 1'b0,1'b0,8'h21, 1'b1, 1'b0,8'h25,1'b0,1'b0,1'b1,2'b10);
    step(1'b1, 1'b1,1'b1,8'h10, 1'b0,1'b0,8'h21, 1'b1, 1'b0,8'h10,1'b1,1'b1,1'b0,2'b01);
    step(1'b1, 1'b1,1'b0,8'h40, 1'b0,1'b0,8'h21, 1'b1, 1'b0,8'h40,1'b0,1'b0,1'b0,2'b00);
    step(1'b1, 1'b0,1'b0,8'h40, 1'b1,1'b0,8'h22, 1'b1, 1'b0,8'h40,1'b0,1'b0,1'b0,2'b00);
    // M1 holds the bus against m0_req for 5 cycles
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1,1'b0,8'h05, 1'b1,1'b0,8'h22, 1'b1, 1'b1,8'h22,1'b0,1'b0,1'b1,
           (i == 0) ? 2'b00 : 2'b01);
    // M1 drops req -> M0 owns after one edge
    step(1'b1, 1'b1,1'b0,8'h05, 1'b0,1'b0,8'h22, 1'b1, 1'b1,8'h22,1'b0,1'b0,1'b0,2'b01);
    step(1'b1, 1'b1,1'b0,8'h05, 1'b0,1'b0,8'h22, 1'b1, 1'b0,8'h05,1'b0,1'b1,1'b0,2'b00);
    // Back to M1, then reset mid-transfer
    step(1'b1, 1'b0,1'b0,8'h05, 1'b1,1'b0,8'h21, 1'b1, 1'b0,8'h05,1'b0,1'b0,1'b0,2'b10);
    step(1'b1, 1'b0,1'b0,8'h05, 1'b1,1'b0,8'h21, 1'b1, 1'b1,8'h21,1'b0,1'b0,1'b1,2'b00);
    step(1'b0, 1'b0,1'b0,8'h05, 1'b1,1'b0,8'h21, 1'b1, 1'b1,8'h21,1'b0,1'b0,1'b1,2'b01);
    step(1'b1, 1'b0,1'b0,8'h05, 1'b1,1'b0,8'h21, 1'b1, 1'b0,8'h05,1'b0,1'b0,1'b0,2'b00);
    // M1 owns; master 0 toggles randomly and must have no effect
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b1,1'b0,8'h21, 1'b1,
           1'b1,8'h21,1'b0,1'b0,1'b1, (i == 0) ? 2'b00 : 2'b01);
    step(1'b1, 1'b1,1'b1,8'h1F, 1'b0,1'b0,8'h21, 1'b1, 1'b1,8'h21,1'b0,1'b0,1'b0,2'b01);
    // M0 owns and writes; master 1 toggles randomly
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1,1'b1,8'h1F, 1'($urandom), 1'($urandom), 8'($urandom), 1'b1,
           1'b0,8'h1F,1'b1,1'b1,1'b0,2'b00);
    // Window edges: 8'h20 first word of s1, 8'h1F last of s0, 8'h3F last of s1
    step(1'b1, 1'b1,1'b0,8'h20, 1'b1,1'b1,8'h00, 1'b1, 1'b0,8'h20,1'b0,1'b0,1'b1,2'b00);
    step(1'b1, 1'b1,1'b0,8'h1F, 1'b0,1'b0,8'h00, 1'b1, 1'b0,8'h1F,1'b0,1'b1,1'b0,2'b01);
    step(1'b1, 1'b1,1'b0,8'h3F, 1'b0,1'b0,8'h00, 1'b1, 1'b0,8'h3F,1'b0,1'b0,1'b1,2'b10);
    step(1'b1, 1'b0,1'b0,8'h3F, 1'b0,1'b0,8'h00, 1'b1, 1'b0,8'h3F,1'b0,1'b0,1'b0,2'b01);
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
